// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix print path: element/address widths,
// error codes, ASCII constants and the FSM state types used by
// matrix_printer and bin2dec_serial.
package matrix_pkg;

  localparam int unsigned ELEMENT_WIDTH   = 8;
  localparam int unsigned BRAM_ADDR_WIDTH = 10;

  localparam logic [3:0] ERR_NONE      = 4'h0;
  localparam logic [3:0] ERR_DIM_RANGE = 4'h1;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [3:0] {
    IDLE, CHECK, HDR, RD_REQ, RD_WAIT, CONV, SEND, GAP, DONE
  } state_e;

  // Which number is currently in the converter / being sent.
  typedef enum logic [1:0] {
    PH_ELEM, PH_HDR_M, PH_HDR_N
  } phase_e;

  typedef enum logic [1:0] {
    B2D_IDLE, B2D_HUND, B2D_TENS
  } b2d_state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2dec_serial.sv
// Serial binary-to-BCD converter by repeated subtraction, one subtraction
// per clock: hundreds first (at most 2), then tens (at most 9); the
// remainder is the units digit.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   go            load value and start a conversion (overrides any in flight)
//   value         unsigned input value
//   done          one-cycle pulse when the digits are final
//   ndigits       significant digit count (1..3), leading zeros suppressed
//   digit2..0     hundreds, tens, units BCD digits
// Results stay stable after done until the next go.
module bin2dec_serial
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [ELEMENT_WIDTH-1:0] value,
  output logic                     done,
  output logic [1:0]               ndigits,
  output logic [3:0]               digit2,
  output logic [3:0]               digit1,
  output logic [3:0]               digit0
);

  b2d_state_e               cst_q, cst_d;
  logic [ELEMENT_WIDTH-1:0] rem_q, rem_d;
  logic [3:0]               hund_q, hund_d;
  logic [3:0]               tens_q, tens_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cst_q  <= B2D_IDLE;
      rem_q  <= '0;
      hund_q <= '0;
      tens_q <= '0;
    end else begin
      cst_q  <= cst_d;
      rem_q  <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
    end
  end

  always_comb begin
    cst_d  = cst_q;
    rem_d  = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    done   = 1'b0;
    case (cst_q)
      B2D_HUND: begin
        if (rem_q >= ELEMENT_WIDTH'(100)) begin
          rem_d  = rem_q - ELEMENT_WIDTH'(100);
          hund_d = hund_q + 4'd1;
        end else begin
          cst_d = B2D_TENS;
        end
      end
      B2D_TENS: begin
        if (rem_q >= ELEMENT_WIDTH'(10)) begin
          rem_d  = rem_q - ELEMENT_WIDTH'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          done  = 1'b1;
          cst_d = B2D_IDLE;
        end
      end
      default: cst_d = B2D_IDLE;
    endcase
    if (go) begin
      rem_d  = value;
      hund_d = '0;
      tens_d = '0;
      cst_d  = B2D_HUND;
    end
  end

  assign ndigits = (hund_q != 4'd0) ? 2'd3 : (tens_q != 4'd0) ? 2'd2 : 2'd1;
  assign digit2  = hund_q;
  assign digit1  = tens_q;
  assign digit0  = rem_q[3:0];

endmodule

// File: rtl/matrix_printer.sv
// Streams a stored matrix to the UART as unsigned decimal ASCII: elements
// row-major, separated by spaces, each row terminated by CR LF.
// Optional feature macro: MATRIX_PRINT_HEADER_EN -- when defined, an
// "<m>x<n>" CR LF header precedes the data, sent through the same
// convert/send path.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, abort      one-cycle request / cancel (abort wins over start)
//   mat_m, mat_n      rows, columns (captured with start)
//   mat_addr          BRAM base address (captured with start)
//   mem_rd_en/addr    BRAM read strobe and address (base + linear index)
//   mem_rd_data       read data, valid one cycle after mem_rd_en
//   tx_data/tx_start  byte and one-cycle transmit pulse to the UART
//   tx_busy           UART busy
//   busy, done        activity flag, one-cycle completion pulse
//   error_code        ERR_NONE / ERR_DIM_RANGE, held until next start
module matrix_printer
  import matrix_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [3:0]                 mat_m,
  input  logic [3:0]                 mat_n,
  input  logic [BRAM_ADDR_WIDTH-1:0] mat_addr,
  output logic                       mem_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0]   mem_rd_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 error_code
);

  state_e                     state_q, state_d;
  phase_e                     phase_q, phase_d;
  logic [3:0]                 m_q, m_d;
  logic [3:0]                 n_q, n_d;
  logic [BRAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [3:0]                 row_q, row_d;
  logic [3:0]                 col_q, col_d;
  logic [7:0]                 idx_q, idx_d;
  logic [2:0]                 pos_q, pos_d;
  logic [3:0]                 err_q, err_d;

  logic                     conv_go;
  logic [ELEMENT_WIDTH-1:0] conv_val;
  logic                     conv_done;
  logic [1:0]               conv_ndig;
  logic [3:0]               conv_d2, conv_d1, conv_d0;

  logic       last_col, last_elem, crlf;
  logic [2:0] nbytes, dsel, sfx;
  logic [7:0] cur_byte;

  bin2dec_serial u_b2d (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (conv_go),
    .value   (conv_val),
    .done    (conv_done),
    .ndigits (conv_ndig),
    .digit2  (conv_d2),
    .digit1  (conv_d1),
    .digit0  (conv_d0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= PH_ELEM;
      m_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      m_q     <= m_d;
      n_q     <= n_d;
      base_q  <= base_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  // Byte stream for the current number: its digits (MSD first), then a
  // suffix of 'x', a space, or CR LF depending on what is being printed.
  always_comb begin
    last_col  = (col_q == n_q - 4'd1);
    last_elem = last_col && (row_q == m_q - 4'd1);
    crlf      = (phase_q == PH_HDR_N) || ((phase_q == PH_ELEM) && last_col);
    nbytes    = {1'b0, conv_ndig} + (crlf ? 3'd2 : 3'd1);
    dsel      = {1'b0, conv_ndig} - pos_q - 3'd1;
    sfx       = pos_q - {1'b0, conv_ndig};
    cur_byte  = '0;
    if (pos_q < {1'b0, conv_ndig}) begin
      case (dsel)
        3'd0:    cur_byte = ascii_digit(conv_d0);
        3'd1:    cur_byte = ascii_digit(conv_d1);
        default: cur_byte = ascii_digit(conv_d2);
      endcase
    end else if (sfx == 3'd0) begin
      if (phase_q == PH_HDR_M) cur_byte = ASCII_X;
      else if (crlf)           cur_byte = ASCII_CR;
      else                     cur_byte = ASCII_SP;
    end else begin
      cur_byte = ASCII_LF;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    m_d       = m_q;
    n_d       = n_q;
    base_d    = base_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    err_d     = err_q;
    conv_go   = 1'b0;
    conv_val  = '0;
    mem_rd_en = 1'b0;
    tx_start  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          m_d     = mat_m;
          n_d     = mat_n;
          base_d  = mat_addr;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          pos_d   = '0;
          err_d   = ERR_NONE;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((m_q == 4'd0) || (n_q == 4'd0)) begin
          err_d   = ERR_DIM_RANGE;
          state_d = DONE;
        end else begin
`ifdef MATRIX_PRINT_HEADER_EN
          phase_d = PH_HDR_M;
          state_d = HDR;
`else
          phase_d = PH_ELEM;
          state_d = RD_REQ;
`endif
        end
      end
`ifdef MATRIX_PRINT_HEADER_EN
      HDR: begin
        conv_go  = 1'b1;
        conv_val = (phase_q == PH_HDR_M) ? ELEMENT_WIDTH'(m_q) : ELEMENT_WIDTH'(n_q);
        state_d  = CONV;
      end
`endif
      RD_REQ: begin
        mem_rd_en = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        // The converter captures the read data on this edge.
        conv_go  = 1'b1;
        conv_val = mem_rd_data;
        state_d  = CONV;
      end
      CONV: begin
        if (conv_done) begin
          pos_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        // One dead cycle so a UART that raises tx_busy late is seen.
        if (pos_q + 3'd1 < nbytes) begin
          pos_d   = pos_q + 3'd1;
          state_d = SEND;
        end else begin
          pos_d = '0;
          case (phase_q)
            PH_HDR_M: begin
              phase_d = PH_HDR_N;
              state_d = HDR;
            end
            PH_HDR_N: begin
              phase_d = PH_ELEM;
              state_d = RD_REQ;
            end
            default: begin
              if (last_elem) begin
                state_d = DONE;
              end else begin
                idx_d = idx_q + 8'd1;
                if (last_col) begin
                  col_d = '0;
                  row_d = row_q + 4'd1;
                end else begin
                  col_d = col_q + 4'd1;
                end
                state_d = RD_REQ;
              end
            end
          endcase
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      mem_rd_en = 1'b0;
      tx_start  = 1'b0;
      done      = 1'b0;
      conv_go   = 1'b0;
    end
  end

  assign mem_rd_addr = base_q + BRAM_ADDR_WIDTH'(idx_q);
  assign tx_data     = (state_q == SEND) ? cur_byte : '0;
  assign busy        = (state_q != IDLE);
  assign error_code  = err_q;

endmodule

// File: tb/tb_matrix_printer.sv
module tb_matrix_printer;
  import matrix_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start, abort;
  logic [3:0]                 mat_m, mat_n;
  logic [BRAM_ADDR_WIDTH-1:0] mat_addr;
  logic                       mem_rd_en;
  logic [BRAM_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [ELEMENT_WIDTH-1:0]   mem_rd_data;
  logic [7:0]                 tx_data;
  logic                       tx_start, tx_busy;
  logic                       busy, done;
  logic [3:0]                 error_code;

  always #5 clk = ~clk;

  matrix_printer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mat_m       (mat_m),
    .mat_n       (mat_n),
    .mat_addr    (mat_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done),
    .error_code  (error_code)
  );

  // BRAM with one-cycle read latency, UART busy for 10 cycles per byte.
  logic [ELEMENT_WIDTH-1:0] mem [0:(1<<BRAM_ADDR_WIDTH)-1];
  int unsigned busy_cnt;
  logic        stall;
  assign tx_busy = (busy_cnt != 0) || stall;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (!rst_n)             busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  int vectors = 0, miscompares = 0;
  int bytes_sent = 0, done_cnt = 0;
  logic [8:0] tx_q [$];
  int         rd_q [$];
  int         exp_b, exp_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every byte and every read popped as the DUT issues it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        if (tx_q.size() != 0) exp_b = int'(tx_q.pop_front());
        else                  exp_b = 'h100;
        check("tx_byte", 32'(tx_data), 32'(exp_b));
        bytes_sent++;
      end
      if (mem_rd_en) begin
        if (rd_q.size() != 0) exp_a = rd_q.pop_front();
        else                  exp_a = -1;
        check("rd_addr", 32'(mem_rd_addr), 32'(exp_a));
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(9'(s[i]));
  endtask

  task automatic push_crlf();
    tx_q.push_back(9'h0D);
    tx_q.push_back(9'h0A);
  endtask

  function automatic int hdr_len(input int m, input int n);
`ifdef MATRIX_PRINT_HEADER_EN
    string s;
    s = $sformatf("%0dx%0d", m, n);
    return s.len() + 2;
`else
    return 0 * (m + n);
`endif
  endfunction

  task automatic push_hdr(input int m, input int n);
`ifdef MATRIX_PRINT_HEADER_EN
    push_str($sformatf("%0dx%0d", m, n));
    push_crlf();
`else
    if (m + n < 0) push_crlf();
`endif
  endtask

  task automatic expect_matrix(input int m, input int n, input int base);
    push_hdr(m, n);
    for (int k = 0; k < m * n; k++) begin
      rd_q.push_back(base + k);
      push_str($sformatf("%0d", mem[base + k]));
      if ((k % n) == n - 1) push_crlf();
      else                  push_str(" ");
    end
  endtask

  task automatic start_op(input int m, input int n, input int base);
    @(posedge clk); #1;
    mat_m = 4'(m); mat_n = 4'(n); mat_addr = BRAM_ADDR_WIDTH'(base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output int seen);
    cyc  = 1;
    seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic wait_bytes(input int target, input int max);
    for (int i = 0; i < max && bytes_sent < target; i++) @(negedge clk);
    check("bytes_reached", 32'(bytes_sent >= target), 32'd1);
  endtask

  task automatic finish_op(input string tag, input int d0, input logic [3:0] err);
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_tx_left"},  32'(tx_q.size()), 32'd0);
    check({tag, "_rd_left"},  32'(rd_q.size()), 32'd0);
    check({tag, "_err"},      32'(error_code), 32'(err));
    check({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog");
  end

  int cyc, seen, d0, b0, h;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    mat_m = '0; mat_n = '0; mat_addr = '0;
    for (int i = 0; i < (1 << BRAM_ADDR_WIDTH); i++) mem[i] = '0;
    mem[16'h010] = 1; mem[16'h011] = 2; mem[16'h012] = 3;
    mem[16'h013] = 4; mem[16'h014] = 5; mem[16'h015] = 6;
    mem[16'h100] = 255; mem[16'h101] = 0; mem[16'h102] = 100;
    mem[16'h200] = 12; mem[16'h201] = 34; mem[16'h202] = 56;
    mem[16'h050] = 7;
    for (int i = 0; i < 225; i++) mem[16'h300 + i] = ELEMENT_WIDTH'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data",  32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_rd_en",    32'(mem_rd_en), 32'd0);
    check("rst_rd_addr",  32'(mem_rd_addr), 32'd0);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_err",      32'(error_code), 32'(ERR_NONE));
    @(posedge clk); #1 rst_n = 1'b1;

    // 2x3 basic
    expect_matrix(2, 3, 'h010);
    d0 = done_cnt;
    start_op(2, 3, 'h010);
    wait_done(5000, cyc, seen);
    check("a_done_seen", 32'(seen), 32'd1);
    finish_op("a", d0, ERR_NONE);

    // 1x3: 3-digit and zero paths
    expect_matrix(1, 3, 'h100);
    d0 = done_cnt;
    start_op(1, 3, 'h100);
    wait_done(5000, cyc, seen);
    check("b_done_seen", 32'(seen), 32'd1);
    finish_op("b", d0, ERR_NONE);

    // Zero rows: error, no traffic, done two cycles after start
    d0 = done_cnt; b0 = bytes_sent;
    start_op(0, 4, 'h010);
    wait_done(20, cyc, seen);
    check("c_done_seen", 32'(seen), 32'd1);
    check("c_latency", 32'(cyc), 32'd2);
    finish_op("c", d0, ERR_DIM_RANGE);
    check("c_no_bytes", 32'(bytes_sent - b0), 32'd0);

    // start together with abort in IDLE: dropped, error code untouched
    @(posedge clk); #1;
    mat_m = 4'd1; mat_n = 4'd1; mat_addr = 'h050; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_err_held", 32'(error_code), 32'(ERR_DIM_RANGE));

    // Zero columns
    d0 = done_cnt;
    start_op(3, 0, 'h010);
    wait_done(20, cyc, seen);
    check("c2_latency", 32'(cyc), 32'd2);
    finish_op("c2", d0, ERR_DIM_RANGE);

    // Long tx_busy stall mid-row
    expect_matrix(2, 3, 'h010);
    d0 = done_cnt;
    b0 = bytes_sent + hdr_len(2, 3) + 4;
    start_op(2, 3, 'h010);
    wait_bytes(b0, 2000);
    @(posedge clk); #1 stall = 1'b1;
    repeat (500) @(posedge clk);
    check("stall_hold", 32'(bytes_sent), 32'(b0));
    #1 stall = 1'b0;
    wait_done(5000, cyc, seen);
    check("d_done_seen", 32'(seen), 32'd1);
    finish_op("d", d0, ERR_NONE);

    // Largest matrix: 225 elements through the 8-bit index
    expect_matrix(15, 15, 'h300);
    d0 = done_cnt;
    start_op(15, 15, 'h300);
    wait_done(20000, cyc, seen);
    check("e_done_seen", 32'(seen), 32'd1);
    finish_op("e", d0, ERR_NONE);

    // Abort while the second element is waiting in SEND
    push_hdr(1, 3);
    rd_q.push_back('h200);
    rd_q.push_back('h201);
    push_str("12 ");
    h  = hdr_len(1, 3);
    d0 = done_cnt;
    b0 = bytes_sent;
    start_op(1, 3, 'h200);
    wait_bytes(b0 + h + 3, 2000);
    @(posedge clk); #1 stall = 1'b1;
    repeat (20) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_busy", 32'(busy), 32'd0);
    stall = 1'b0;
    repeat (60) @(negedge clk);
    check("ab_bytes", 32'(bytes_sent - b0), 32'(h + 3));
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);
    check("ab_tx_left", 32'(tx_q.size()), 32'd0);
    check("ab_rd_left", 32'(rd_q.size()), 32'd0);

    // 1x1 after abort
    expect_matrix(1, 1, 'h050);
    d0 = done_cnt;
    start_op(1, 1, 'h050);
    wait_done(2000, cyc, seen);
    check("f_done_seen", 32'(seen), 32'd1);
    finish_op("f", d0, ERR_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
